// File: rtl/mips_pkg.sv
// Shared constants for the MIPS register file and its pending-write scoreboard.
package mips_pkg;

    // Default register width and register-number width.
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Register count at the default register-number width.
    localparam int NUM_REGS = 2 ** DEF_ADDR_W;

    // r0 is hardwired to zero: never stored to, never marked busy.
    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One-hot decode of a register number into a busy-sized vector.
    // When en is low the result is all zeros.
    function automatic logic [NUM_REGS-1:0] reg_onehot(
        input logic                  en,
        input logic [DEF_ADDR_W-1:0] idx
    );
        logic [NUM_REGS-1:0] v;
        v = '0;
        if (en) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/mips_scoreboard.sv
// Pending-write scoreboard: tracks which registers have an outstanding
// producer and blocks issue of any instruction that reads or rewrites one.
//
// Handshake: issue_valid / issue_stall form a valid/ready pair with
// ready = !issue_stall. An instruction transfers on a rising edge where
// issue_valid is high and issue_stall is low; issue_stall is only ever high
// while issue_valid is high, and the issuer must hold its request stable
// until it transfers.
module mips_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int REGS   = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic [REGS-1:0]   busy,
    output logic              issue_stall
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [REGS-1:0] busy_q;
    logic [REGS-1:0] busy_d;
    logic [REGS-1:0] clr_vec;
    logic [REGS-1:0] set_vec;
    logic [REGS-1:0] eff_busy;
    logic            hazard;
    logic            issue_accept;

    // Release decode: a same-cycle writeback frees its register immediately,
    // so a consumer may issue in the producer's writeback cycle.
    always_comb begin
        clr_vec = '0;
        if (wb_en) begin
            clr_vec[wb_addr] = 1'b1;
        end
        eff_busy = busy_q & ~clr_vec;
    end

    // Hazard detection: RAW on either source, plus WAW on the destination so
    // that no register ever has more than one outstanding producer.
    always_comb begin
        hazard = eff_busy[rs_addr]
               | eff_busy[rt_addr]
               | (issue_we & eff_busy[issue_dst]);
        issue_stall  = issue_valid & hazard;
        issue_accept = issue_valid & ~hazard;
    end

    // Next busy vector: clears first, then the new producer's set on top so
    // that set wins when one register is both retired and re-claimed.
    always_comb begin
        set_vec = '0;
        if (issue_accept && issue_we && (issue_dst != ZERO_IDX)) begin
            set_vec[issue_dst] = 1'b1;
        end
        busy_d           = (busy_q & ~clr_vec) | set_vec;
        busy_d[ZERO_IDX] = 1'b0;
    end

    // Busy state register; reset drops every pending write at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/mips_regfile.sv
// MIPS general-purpose register file: storage array, two combinational read
// ports with write-through bypass, and the pending-write scoreboard.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      rs_addr,
    input  logic [ADDR_W-1:0]      rt_addr,
    output logic [DATA_W-1:0]      rs_data,
    output logic [DATA_W-1:0]      rt_data,
    input  logic                   issue_valid,
    input  logic                   issue_we,
    input  logic [ADDR_W-1:0]      issue_dst,
    output logic                   issue_stall,
    input  logic                   wb_en,
    input  logic [ADDR_W-1:0]      wb_addr,
    input  logic [DATA_W-1:0]      wb_data,
    output logic [(2**ADDR_W)-1:0] busy
);

    localparam int                REGS     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [REGS];
    logic              wb_store;

    // Read-port selection: r0 reads zero, a matching writeback is forwarded,
    // otherwise the stored value.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic              fwd_en,
        input logic [ADDR_W-1:0] fwd_addr,
        input logic [DATA_W-1:0] fwd_data,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] v;
        if (addr == ZERO_IDX) begin
            v = '0;
        end else if (fwd_en && (fwd_addr == addr)) begin
            v = fwd_data;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    // Writes to r0 are dropped here so the array never holds a nonzero r0.
    assign wb_store = wb_en && (wb_addr != ZERO_IDX);

    // Storage array; reset clears every register, losing any in-flight write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_store) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Operand read ports with write-through bypass from the writeback bus.
    always_comb begin
        rs_data = read_port(rs_addr, wb_en, wb_addr, wb_data, regs[rs_addr]);
        rt_data = read_port(rt_addr, wb_en, wb_addr, wb_data, regs[rt_addr]);
    end

    mips_scoreboard #(
        .ADDR_W (ADDR_W),
        .REGS   (REGS)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_dst   (issue_dst),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .busy        (busy),
        .issue_stall (issue_stall)
    );

endmodule

// File: tb/tb_mips_regfile.sv
// Bench for mips_regfile: directed vectors with hand-computed results, then
// randomised independent traffic checked against a reference array and busy
// model.
module tb_mips_regfile;

    localparam int EXP_W = 65;  // {stall, rs_data, rt_data}

    logic        clk;
    logic        rst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        issue_valid;
    logic        issue_we;
    logic [4:0]  issue_dst;
    logic        issue_stall;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] busy;

    int n_vec;
    int n_err;

    logic [EXP_W-1:0] exp_q [$];
    logic [31:0]      ref_regs [32];
    logic [31:0]      ref_busy;
    int               pend_q [$];

    mips_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_dst   (issue_dst),
        .issue_stall (issue_stall),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .busy        (busy)
    );

    // Clock and power-on reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every vector and reports misses.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_addr     = '0;
        rt_addr     = '0;
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_dst   = '0;
        wb_en       = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
    endtask

    task automatic drive_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
        wb_en   = en;
        wb_addr = addr;
        wb_data = data;
    endtask

    task automatic drive_issue(input logic v, input logic we, input logic [4:0] dst,
                               input logic [4:0] rs, input logic [4:0] rt);
        issue_valid = v;
        issue_we    = we;
        issue_dst   = dst;
        rs_addr     = rs;
        rt_addr     = rt;
    endtask

    // Reference read: r0 zero, writeback forwarded, else model array.
    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return ref_regs[a];
    endfunction

    task automatic random_phase(input int cycles);
        logic [31:0] clr;
        logic [31:0] eff;
        logic        hz;
        logic        stl;
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] got;
        int k;
        for (int c = 0; c < cycles; c++) begin
            check("rnd_busy", 64'(busy), 64'(ref_busy));
            check("rnd_busy0", 64'(busy[0]), 64'(0));
            drive_issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                        5'($urandom_range(0, 31)));
            drive_wb(1'b0, 5'd0, 32'h0);
            if (pend_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                k = int'($urandom_range(0, pend_q.size() - 1));
                drive_wb(1'b1, 5'(pend_q[k]), $urandom);
                pend_q.delete(k);
            end else if ($urandom_range(0, 7) == 0) begin
                wb_addr = 5'($urandom_range(0, 31));
                if (ref_busy[wb_addr] == 1'b0) begin
                    wb_en   = 1'b1;
                    wb_data = $urandom;
                end
            end
            clr = 32'h0;
            if (wb_en) clr[wb_addr] = 1'b1;
            eff = ref_busy & ~clr;
            hz  = eff[rs_addr] | eff[rt_addr] | (issue_we & eff[issue_dst]);
            stl = issue_valid & hz;
            exp_q.push_back({stl, ref_read(rs_addr), ref_read(rt_addr)});
            #2;
            e   = exp_q.pop_front();
            got = {issue_stall, rs_data, rt_data};
            check("rnd_stall", 64'(got[64]), 64'(e[64]));
            check("rnd_rs", 64'(got[63:32]), 64'(e[63:32]));
            check("rnd_rt", 64'(got[31:0]), 64'(e[31:0]));
            if (wb_en && wb_addr != 5'd0) ref_regs[wb_addr] = wb_data;
            ref_busy = eff;
            if (issue_valid && !stl && issue_we && issue_dst != 5'd0) begin
                ref_busy[issue_dst] = 1'b1;
                pend_q.push_back(int'(issue_dst));
            end
            step();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle();
        rst = 1'b1;
        #12;
        check("rst_rs", 64'(rs_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_stall", 64'(issue_stall), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        step();

        // Mid-run reset discards stored data and pending writes.
        drive_wb(1'b1, 5'd5, 32'hDEADBEEF);
        drive_issue(1'b1, 1'b1, 5'd6, 5'd0, 5'd0);
        step();
        idle();
        rs_addr = 5'd5;
        #2;
        check("pre_rst_r5", 64'(rs_data), 64'hDEADBEEF);
        check("pre_rst_busy", 64'(busy), 64'h40);
        rst = 1'b1;
        issue_valid = 1'b1;
        rt_addr     = 5'd6;
        #1;
        check("mid_rst_r5", 64'(rs_data), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_stall", 64'(issue_stall), 64'(0));
        step();
        rst = 1'b0;
        idle();
        step();

        // Write/read and r0 discard.
        drive_wb(1'b1, 5'd8, 32'h12345678);
        step();
        drive_wb(1'b1, 5'd0, 32'hFFFFFFFF);
        step();
        idle();
        drive_issue(1'b0, 1'b0, 5'd0, 5'd8, 5'd0);
        #2;
        check("rd_r8", 64'(rs_data), 64'h12345678);
        check("rd_r0", 64'(rt_data), 64'(0));
        drive_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
        #2;
        check("r0_issue_stall", 64'(issue_stall), 64'(0));
        step();
        idle();
        check("r0_not_busy", 64'(busy), 64'(0));

        // Write-through bypass in the write cycle itself.
        drive_wb(1'b1, 5'd9, 32'hA5A5A5A5);
        rs_addr = 5'd9;
        rt_addr = 5'd9;
        #2;
        check("byp_rs", 64'(rs_data), 64'hA5A5A5A5);
        check("byp_rt", 64'(rt_data), 64'hA5A5A5A5);
        step();
        wb_en = 1'b0;
        #2;
        check("stored_r9", 64'(rs_data), 64'hA5A5A5A5);
        step();

        // RAW stall and release in the producer's writeback cycle.
        idle();
        drive_issue(1'b1, 1'b1, 5'd3, 5'd0, 5'd0);
        #2;
        check("raw_prod_accept", 64'(issue_stall), 64'(0));
        step();
        idle();
        check("raw_busy3", 64'(busy), 64'h8);
        drive_issue(1'b1, 1'b0, 5'd0, 5'd3, 5'd0);
        #2;
        check("raw_stall", 64'(issue_stall), 64'(1));
        step();
        check("raw_stall_hold", 64'(issue_stall), 64'(1));
        drive_wb(1'b1, 5'd3, 32'h00003333);
        #2;
        check("raw_release", 64'(issue_stall), 64'(0));
        check("raw_fwd", 64'(rs_data), 64'h00003333);
        step();
        idle();
        check("raw_busy_clr", 64'(busy), 64'(0));

        // WAW stall, then set-wins when retire and re-claim coincide.
        drive_issue(1'b1, 1'b1, 5'd4, 5'd0, 5'd0);
        step();
        check("waw_busy4", 64'(busy), 64'h10);
        #2;
        check("waw_stall", 64'(issue_stall), 64'(1));
        drive_wb(1'b1, 5'd4, 32'h00004444);
        #2;
        check("waw_accept", 64'(issue_stall), 64'(0));
        step();
        idle();
        check("set_wins", 64'(busy), 64'h10);
        rs_addr = 5'd4;
        #2;
        check("waw_data", 64'(rs_data), 64'h00004444);
        drive_wb(1'b1, 5'd4, 32'h00004445);
        step();
        idle();
        check("waw_clr", 64'(busy), 64'(0));

        // Writeback to a non-busy register writes data, leaves busy at 0.
        drive_wb(1'b1, 5'd10, 32'hCAFEF00D);
        step();
        idle();
        rt_addr = 5'd10;
        #2;
        check("nb_wb_busy", 64'(busy), 64'(0));
        check("nb_wb_data", 64'(rt_data), 64'hCAFEF00D);

        // Clean slate, then randomised independent traffic.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        idle();
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        ref_busy = 32'h0;
        step();
        random_phase(10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_regfile.md
# mips_regfile

General-purpose register file for the MIPS datapath, with a pending-write scoreboard. It consumes the destination-register number chosen by the RegDst select (rt or rd) at issue, and the writeback address and data at the end of the pipe. It supplies the two source operands to decode and raises an issue stall while any operand or the destination still has an outstanding write.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register-number width (2**ADDR_W registers)

Ports:
- clk  in  1  single system clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high
- rs_addr  in  ADDR_W  source register 1 number
- rt_addr  in  ADDR_W  source register 2 number
- rs_data  out  DATA_W  operand 1, combinational
- rt_data  out  DATA_W  operand 2, combinational
- issue_valid  in  1  an instruction is presented for issue this cycle
- issue_we  in  1  the issuing instruction writes a register
- issue_dst  in  ADDR_W  destination number from the RegDst select
- issue_stall  out  1  issue blocked this cycle, combinational
- wb_en  in  1  writeback this cycle
- wb_addr  in  ADDR_W  writeback register number
- wb_data  in  DATA_W  writeback value
- busy  out  2**ADDR_W  scoreboard bit vector, registered

## Operation
- **Storage:** 2**ADDR_W registers of DATA_W bits.
  - Register 0 is hardwired to 0. Writes to it are discarded and it never becomes busy.
- **Reads:** combinational.
  - rs_data = 0 if rs_addr == 0.
  - Otherwise, if wb_en and wb_addr == rs_addr, rs_data = wb_data (write-through bypass).
  - Otherwise rs_data = the stored value.
  - rt_data follows the same rules with rt_addr.
- **Write:** on the clock edge when wb_en and wb_addr != 0, reg[wb_addr] <= wb_data.
- **Effective busy (eff_busy):** busy[n] and not (wb_en and wb_addr == n). A same-cycle writeback releases its register.
- **Hazard:** hazard = eff_busy[rs_addr] or eff_busy[rt_addr] or (issue_we and eff_busy[issue_dst]).
  - The last term is the WAW check. Because of it, at most one write per register is ever outstanding.
- **Stall:** issue_stall = issue_valid and hazard.
- **Issue accepted:** issue_valid and not issue_stall.
- **Busy set:** on the clock edge when an issue is accepted, issue_we is high and issue_dst != 0, busy[issue_dst] <= 1.
- **Busy clear:** on the clock edge when wb_en, busy[wb_addr] <= 0.
- **Same register set and cleared in one cycle:** set wins, so busy stays 1. This is the new producer.
- **Writeback to a non-busy register:** legal. It writes the data and busy stays 0.
- **No internal state machine.** State is the register array plus the busy vector.
- **Reset:**
  - All registers are 0 and busy = 0.
  - Consequences: rs_data = rt_data = 0 (unless bypass is active) and issue_stall = 0.
  - Reset asserted mid-operation discards any pending writes immediately. A writeback in flight on the cycle reset is asserted is lost.

## Timing
- Read latency: 0 cycles.
  - Stored data is visible on the cycle after the write edge.
  - The bypass makes it visible in the write cycle itself.
- issue_stall has 0-cycle latency from its inputs; there is no registered path.
- busy changes only on clock edges, 1 cycle after the qualifying issue or writeback.
- Minimum producer-to-consumer issue spacing: an issue can be accepted in the same cycle as the producer's writeback.
- Combinational paths:
  - wb_addr/wb_en → issue_stall
  - wb_data → rs_data/rt_data
  - The next pipeline stage must register these.

## Structure
- A shared package mips_pkg holds:
  - DATA_W and ADDR_W defaults
  - REG_ZERO (5'd0)
  - NUM_REGS
- One natural sub-module, mips_scoreboard:
  - Contents: the busy vector, set/clear logic, eff_busy and the hazard/stall logic.
  - Inputs: clk, rst, rs_addr, rt_addr, issue_* and wb_en/wb_addr.
  - Outputs: busy and issue_stall.
- The storage array and the bypass muxes live in the top module.

## Test plan
- **Reset:**
  - Stimulus: assert rst mid-run after writing 0xDEADBEEF to r5, then release.
  - Required: reading r5 → 0, busy == 0, issue_stall == 0.
- **Write/read and r0:**
  - Stimulus 1: write 0x12345678 to r8, then 0xFFFFFFFF to r0. Next cycle rs_addr=8, rt_addr=0.
  - Required: rs_data=0x12345678, rt_data=0.
  - Stimulus 2: issue with issue_we=1, issue_dst=0.
  - Required: busy[0] stays 0.
- **Bypass:**
  - Stimulus: wb_en=1, wb_addr=9, wb_data=0xA5A5A5A5 with rs_addr=rt_addr=9 in the same cycle.
  - Required: both outputs 0xA5A5A5A5 that cycle.
- **RAW stall:**
  - Step 1: issue dst=3 (RegDst result), accepted. Required: busy[3]=1 next cycle.
  - Step 2: issue with rs_addr=3. Required: issue_stall=1.
  - Step 3: the cycle wb_en=1, wb_addr=3. Required: issue_stall=0, rs_data=wb_data.
- **WAW and set-wins:**
  - Stimulus 1: busy[4]=1, issue dst=4. Required: stall.
  - Stimulus 2: in the same cycle, writeback to r4 and an accepted issue with dst=4. Required: busy[4]=1 afterwards.
- **Independent traffic:**
  - Stimulus: random issues and writebacks to distinct registers, checked against a reference array and busy model.
  - Required: no mismatch over 10k cycles; busy never set for r0.
